pc_ras: RTL and testbench

- Parametrised next-generation program counter. Generalises the fetch PC with configurable word width, reset vector and increment.
- Adds a selectable next-PC mode set, a stall qualifier, and a circular return-address stack (RAS) for call/return prediction.
- Sits between the control/hazard logic and instruction memory. Drives imemaddr every cycle; consumes the fetch handshake (ihit) and the pipeline stall.

---
 rtl/pc_ras.sv | 128 ++++++++++++
 tb/tb_pc_ras.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Fetch program counter with selectable next-PC modes and a circular return-address
// stack for call/return prediction. The PC and the RAS advance only on ihit & ~stall.
module pc_ras #(
  parameter int                 WORD_W    = 32,
  parameter logic [WORD_W-1:0]  RESET_PC  = '0,
  parameter int                 PC_INC    = 4,
  parameter int                 RAS_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              stall,
  input  logic [2:0]        pc_select,
  input  logic [WORD_W-1:0] target,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] rtn_addr,
  output logic [WORD_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              misalign
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [WORD_W-1:0] INC   = WORD_W'(PC_INC);
  localparam logic [WORD_W-1:0] LOW   = WORD_W'(PC_INC - 1);
  localparam logic [CW-1:0]     DEPTH = CW'(RAS_DEPTH);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_J    = 3'd2;
  localparam logic [2:0] SEL_JR   = 3'd3;
  localparam logic [2:0] SEL_CALL = 3'd4;
  localparam logic [2:0] SEL_RET  = 3'd5;

  logic [WORD_W-1:0] r_pc;
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf, r_unf, r_mis;
  logic [WORD_W-1:0] r_ras [RAS_DEPTH];

  logic              w_upd, w_empty, w_full;
  logic [WORD_W-1:0] w_tgt_al, w_pc_nxt;
  logic              w_tgt_mis;
  logic [PW-1:0]     w_ptr_inc, w_ptr_dec;
  logic              w_push, w_pop, w_unf, w_mis;

  assign w_upd     = ihit & ~stall;
  assign w_tgt_al  = target & ~LOW;
  assign w_tgt_mis = |(target & LOW);
  assign w_ptr_inc = r_ptr + PW'(1);
  assign w_ptr_dec = r_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH);

  assign imemaddr  = r_pc;
  assign rtn_addr  = r_pc + INC;
  assign ras_top   = w_empty ? '0 : r_ras[r_ptr];
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;
  assign misalign  = r_mis;

  always_comb begin
    w_pc_nxt = r_pc + INC;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_unf    = 1'b0;
    w_mis    = 1'b0;
    case (pc_select)
      SEL_BR, SEL_J, SEL_JR: begin
        w_pc_nxt = w_tgt_al;
        w_mis    = w_tgt_mis;
      end
      SEL_CALL: begin
        w_pc_nxt = w_tgt_al;
        w_push   = 1'b1;
        w_mis    = w_tgt_mis;
      end
      SEL_RET: begin
        if (!w_empty) begin
          w_pc_nxt = r_ras[r_ptr];
          w_pop    = 1'b1;
        end else begin
          // Empty stack: fall back to the supplied target like a jump.
          w_pc_nxt = w_tgt_al;
          w_unf    = 1'b1;
          w_mis    = w_tgt_mis;
        end
      end
      default: w_pc_nxt = r_pc + INC;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc  <= RESET_PC;
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_mis <= w_upd & w_mis;
      if (w_upd) begin
        r_pc <= w_pc_nxt;
        if (w_push) begin
          r_ptr <= w_ptr_inc;
          if (w_full) r_ovf <= 1'b1;
          else        r_cnt <= r_cnt + CW'(1);
        end else if (w_pop) begin
          r_ptr <= w_ptr_dec;
          r_cnt <= r_cnt - CW'(1);
        end
        if (w_unf) r_unf <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge CLK) begin
    if (nRST && w_upd && w_push) r_ras[w_ptr_inc] <= rtn_addr;
  end

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the PC and return-address stack.
module tb_pc_ras;
  localparam logic [31:0] RPC = 32'h40;
  localparam int          DEP = 8;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall;
  logic [2:0]  pc_select;
  logic [31:0] target;
  logic [31:0] imemaddr, rtn_addr, ras_top;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

  pc_ras #(.WORD_W(32), .RESET_PC(RPC), .PC_INC(4), .RAS_DEPTH(DEP)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .pc_select(pc_select),
    .target(target), .imemaddr(imemaddr), .rtn_addr(rtn_addr), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf, m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = RPC;
    m_ras.delete();
    m_ovf = 0;
    m_unf = 0;
    m_mis = 0;
  endfunction

  // Next state from the architectural rules, using the inputs seen at the edge.
  function automatic void model_step();
    logic [31:0] al;
    bit          lowbits;
    al      = target & ~32'h3;
    lowbits = (target[1:0] != 2'b00);
    m_mis   = 0;
    if (!(ihit && !stall)) return;
    case (pc_select)
      3'd1, 3'd2, 3'd3: begin m_pc = al; m_mis = lowbits; end
      3'd4: begin
        if (m_ras.size() == DEP) begin void'(m_ras.pop_front()); m_ovf = 1; end
        m_ras.push_back(m_pc + 32'd4);
        m_pc  = al;
        m_mis = lowbits;
      end
      3'd5: begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = al; m_unf = 1; m_mis = lowbits; end
      end
      default: m_pc = m_pc + 32'd4;
    endcase
  endfunction

  always @(negedge CLK) begin
    chk("imemaddr", imemaddr, m_pc);
    chk("rtn_addr", rtn_addr, m_pc + 32'd4);
    chk("ras_top", ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'h0);
    chk("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    chk("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEP});
    chk("ras_ovf", {31'b0, ras_ovf}, {31'b0, m_ovf});
    chk("ras_unf", {31'b0, ras_unf}, {31'b0, m_unf});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
  end

  task automatic step(input logic [2:0] s, input logic [31:0] t,
                      input bit ih = 1'b1, input bit st = 1'b0);
    pc_select = s;
    target    = t;
    ihit      = ih;
    stall     = st;
    @(posedge CLK);
    if (nRST) model_step();
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; pc_select = 3'd0; target = 32'h0;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_pc", imemaddr, 32'h40);
    chk("rst_empty", {31'b0, ras_empty}, 32'h1);
    chk("rst_flags", {29'b0, ras_ovf, ras_unf, misalign}, 32'h0);
    nRST = 1'b1;

    step(3'd0, 0); chk("seq1", imemaddr, 32'h44); chk("seq1_rtn", rtn_addr, 32'h48);
    step(3'd0, 0); chk("seq2", imemaddr, 32'h48);
    step(3'd0, 0); chk("seq3", imemaddr, 32'h4C); chk("seq3_rtn", rtn_addr, 32'h50);

    step(3'd2, 32'h100); chk("jmp100", imemaddr, 32'h100);
    step(3'd2, 32'h999, 1'b0, 1'b0); chk("nohit1", imemaddr, 32'h100);
    step(3'd2, 32'h999, 1'b0, 1'b0); chk("nohit2", imemaddr, 32'h100);
    step(3'd2, 32'h999, 1'b1, 1'b1); chk("stall", imemaddr, 32'h100);
    step(3'd2, 32'h200); chk("jmp200", imemaddr, 32'h200);

    step(3'd2, 32'h100);
    step(3'd4, 32'h300); chk("call1", imemaddr, 32'h300);
    step(3'd4, 32'h400); chk("call2", imemaddr, 32'h400); chk("call2_top", ras_top, 32'h304);
    step(3'd5, 0); chk("ret1", imemaddr, 32'h304);
    step(3'd5, 0); chk("ret2", imemaddr, 32'h104);
    chk("ret2_empty", {31'b0, ras_empty}, 32'h1);

    for (int i = 0; i < 9; i++) step(3'd4, 32'h1000 + 32'(i) * 32'h10);
    chk("ovf_full", {30'b0, ras_full, ras_ovf}, 32'h3);
    chk("ovf_top", ras_top, 32'h1074);
    for (int k = 0; k < 8; k++) begin
      step(3'd5, 32'hDEAD0000);
      chk("lifo_ret", imemaddr, 32'h1074 - 32'(k) * 32'h10);
    end
    chk("lifo_empty", {31'b0, ras_empty}, 32'h1);

    step(3'd5, 32'h500); chk("unf_pc", imemaddr, 32'h500);
    chk("unf_flag", {31'b0, ras_unf}, 32'h1);
    step(3'd3, 32'h603); chk("jr_al", imemaddr, 32'h600);
    chk("mis_on", {31'b0, misalign}, 32'h1);
    step(3'd0, 0); chk("mis_off", {31'b0, misalign}, 32'h0);
    chk("seq604", imemaddr, 32'h604);

    step(3'd1, 32'hFFFFFFFC); chk("top_pc", imemaddr, 32'hFFFFFFFC);
    step(3'd7, 0); chk("wrap", imemaddr, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [2:0]  s;
      r = $urandom_range(0, 9);
      if (r < 3)      s = 3'd4;
      else if (r < 6) s = 3'd5;
      else            s = 3'($urandom_range(0, 7));
      step(s, $urandom, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
    end
    chk("unf_sticky", {31'b0, ras_unf}, 32'h1);

    step(3'd4, 32'h300);
    pc_select = 3'd4; target = 32'h700; ihit = 1'b1; stall = 1'b0;
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("arst_pc", imemaddr, 32'h40);
    chk("arst_empty", {31'b0, ras_empty}, 32'h1);
    chk("arst_flags", {29'b0, ras_ovf, ras_unf, misalign}, 32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    step(3'd0, 0); chk("post_rst", imemaddr, 32'h44);
    @(negedge CLK); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
